// File: rtl/ecsm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ecsm_ctrl
//  Description : Left-to-right double-and-add sequencer computing R = k*P by
//                issuing every point operation to one shared ECPA instance.
//  Revision    : 1.0  initial release
// ============================================================================

module ecsm_ctrl #(
    parameter int W   = 256,
    parameter int K_W = 256
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [K_W-1:0] i_k,
    input  logic [W-1:0]   p,
    input  logic [W-1:0]   Px,
    input  logic [W-1:0]   Py,
    input  logic [W-1:0]   Pz,
    output logic           o_busy,
    output logic           o_done,
    output logic [W-1:0]   Rx,
    output logic [W-1:0]   Ry,
    output logic [W-1:0]   Rz,
    output logic           o_pa_start,
    output logic [W-1:0]   o_pa_X1,
    output logic [W-1:0]   o_pa_Y1,
    output logic [W-1:0]   o_pa_Z1,
    output logic [W-1:0]   o_pa_X2,
    output logic [W-1:0]   o_pa_Y2,
    output logic [W-1:0]   o_pa_Z2,
    output logic [W-1:0]   o_pa_p,
    input  logic [W-1:0]   i_pa_X3,
    input  logic [W-1:0]   i_pa_Y3,
    input  logic [W-1:0]   i_pa_Z3,
    input  logic           i_pa_done
);

    localparam int                 c_IDX_W   = (K_W > 1) ? $clog2(K_W) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_MSB = c_IDX_W'(K_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCAN    = 3'd1,
        S_DBL     = 3'd2,
        S_DBL_GAP = 3'd3,
        S_ADD     = 3'd4,
        S_ADD_GAP = 3'd5,
        S_FIN     = 3'd6
    } state_t;

    state_t             r_state, w_state_next;
    logic [K_W-1:0]     r_kreg;
    logic [W-1:0]       r_px, r_py, r_pz;
    logic [W-1:0]       r_x, r_y, r_z;
    logic [W-1:0]       w_x_next, w_y_next, w_z_next;
    logic [c_IDX_W-1:0] r_idx, w_idx_next;
    logic               w_kbit;
    logic               w_accept;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_kreg  <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_pz    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_idx   <= c_IDX_MSB;
            Rx      <= '0;
            Ry      <= '0;
            Rz      <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_z     <= w_z_next;
            if (w_accept) begin
                r_kreg <= i_k;
                r_px   <= Px;
                r_py   <= Py;
                r_pz   <= Pz;
            end
            // Result is published on the same edge that enters FIN so it is valid with o_done.
            if (w_state_next == S_FIN) begin
                Rx <= w_x_next;
                Ry <= w_y_next;
                Rz <= w_z_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_z_next     = r_z;
        w_accept     = 1'b0;
        w_kbit       = r_kreg[r_idx];
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_idx_next   = c_IDX_MSB;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_kbit) begin
                    w_x_next = r_px;
                    w_y_next = r_py;
                    w_z_next = r_pz;
                    if (r_idx == '0) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_idx_next   = r_idx - 1'b1;
                        w_state_next = S_DBL;
                    end
                end else if (r_idx != '0) begin
                    w_idx_next = r_idx - 1'b1;
                end else begin
                    // k = 0: result is the point at infinity
                    w_x_next     = '0;
                    w_y_next     = W'(1);
                    w_z_next     = '0;
                    w_state_next = S_FIN;
                end
            end
            S_DBL, S_ADD: begin
                if (i_pa_done) begin
                    w_x_next     = i_pa_X3;
                    w_y_next     = i_pa_Y3;
                    w_z_next     = i_pa_Z3;
                    w_state_next = (r_state == S_DBL) ? S_DBL_GAP : S_ADD_GAP;
                end
            end
            S_DBL_GAP: begin
                if (w_kbit) begin
                    w_state_next = S_ADD;
                end else if (r_idx == '0) begin
                    w_state_next = S_FIN;
                end else begin
                    w_idx_next   = r_idx - 1'b1;
                    w_state_next = S_DBL;
                end
            end
            S_ADD_GAP: begin
                if (r_idx == '0) begin
                    w_state_next = S_FIN;
                end else begin
                    w_idx_next   = r_idx - 1'b1;
                    w_state_next = S_DBL;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand 1 is always R; operand 2 is R for a doubling and the base point for an add.
    assign o_pa_start = (r_state == S_DBL) || (r_state == S_ADD);
    assign o_pa_X1    = r_x;
    assign o_pa_Y1    = r_y;
    assign o_pa_Z1    = r_z;
    assign o_pa_X2    = (r_state == S_ADD) ? r_px : r_x;
    assign o_pa_Y2    = (r_state == S_ADD) ? r_py : r_y;
    assign o_pa_Z2    = (r_state == S_ADD) ? r_pz : r_z;
    assign o_pa_p     = p;

    assign o_busy = (r_state != S_IDLE) && (r_state != S_FIN);
    assign o_done = (r_state == S_FIN);

endmodule

`default_nettype wire

// File: doc/ecsm_ctrl.md
# ecsm_ctrl

Scalar-multiplication sequencer for the shared ECPA point-adder. It computes R = k·P in projective coordinates using left-to-right double-and-add, issuing every point operation to one external ECPA instance over its start/done handshake. Doubling is issued as ECPA with both operands equal to R. The ECPA implementation uses complete formulas, so P+P and operands at infinity are valid. The block sits between the key/command layer and the ECPA datapath and owns no field arithmetic itself.

## Interface
- W, 256, coordinate and modulus width
- K_W, 256, scalar width
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  request; sampled only in IDLE
- i_k  in  K_W  scalar, latched on accepted start
- p  in  W  modulus, forwarded to ECPA, must be stable while o_busy
- Px, Py, Pz  in  W each  base point, latched on accepted start
- o_busy  out  1  high from the cycle after an accepted start until o_done
- o_done  out  1  one-cycle pulse, result valid
- Rx, Ry, Rz  out  W each  result, held until the next accepted start
- o_pa_start  out  1  ECPA start, level, held until ECPA done is sampled
- o_pa_X1, o_pa_Y1, o_pa_Z1, o_pa_X2, o_pa_Y2, o_pa_Z2  out  W each  ECPA operands, stable while o_pa_start is high
- o_pa_p  out  W  equals p
- i_pa_X3, i_pa_Y3, i_pa_Z3  in  W each  ECPA result
- i_pa_done  in  1  ECPA completion, sampled only while o_pa_start is high

## Operation
- States: IDLE, SCAN, DBL, DBL_GAP, ADD, ADD_GAP, FIN.
- IDLE:
  - i_start=1 latches i_k into kreg and P into preg.
  - Sets idx=K_W-1 and moves to SCAN.
- SCAN, one bit per cycle:
  - kreg[idx]=1: set R=preg. If idx=0, go to FIN. Otherwise set idx=idx-1 and go to DBL.
  - kreg[idx]=0 and idx>0: set idx=idx-1 and stay in SCAN.
  - kreg[idx]=0 and idx=0 (k=0): set R=(0,1,0), the point at infinity, and go to FIN.
- DBL:
  - o_pa_start=1, operands 1 and 2 both equal R.
  - On i_pa_done=1: R=i_pa_X3/Y3/Z3, go to DBL_GAP.
- DBL_GAP:
  - o_pa_start=0 for exactly one cycle.
  - kreg[idx]=1: go to ADD.
  - kreg[idx]=0 and idx=0: go to FIN.
  - Otherwise: set idx=idx-1 and go to DBL.
- ADD:
  - o_pa_start=1, operand 1 is R, operand 2 is preg.
  - On i_pa_done=1: capture R, go to ADD_GAP.
- ADD_GAP:
  - o_pa_start=0 for one cycle.
  - idx=0: go to FIN.
  - Otherwise: set idx=idx-1 and go to DBL.
- FIN:
  - Rx/Ry/Rz=R, o_done=1 for one cycle, return to IDLE.
- ECPA op count:
  - Doublings: (bitlength(k)-1).
  - Additions: popcount(k)-1.
  - k=0 and k=1 issue no ECPA op.
- i_start while o_busy is ignored; no queueing.
- Inputs P and i_k may change after acceptance without effect; p may not.

## Timing
- Reset (async, immediate): state=IDLE, o_busy=0, o_done=0, o_pa_start=0, Rx=Ry=Rz=0, all o_pa operands 0, kreg=preg=0, idx=K_W-1.
- Reset mid-operation aborts the operation; the bench must also reset ECPA.
- Accepted start at edge t: o_busy=1 from edge t. SCAN occupies K_W-1-msb(k)+1 cycles.
- Each ECPA op: o_pa_start rises on entry to DBL/ADD. It falls the cycle after i_pa_done is sampled high, followed by exactly one low gap cycle.
- With an ECPA latency of L cycles (start high to done high), each op costs L+2 cycles.
- Total latency from accept to o_done: 1 + (K_W-msb(k)) + ops·(L+2) + 1. For k=0, SCAN costs K_W cycles.
- o_busy falls in the same cycle o_done pulses, so a new i_start is accepted in the cycle after o_done.
- i_pa_done high while o_pa_start=0 is ignored.

## Test plan
- Bench uses a behavioural ECPA stub with L=4 that logs each operand pair; K_W=8, W=256, p=23.
- k=0 -> no o_pa_start ever; o_done after 10 cycles; R=(0,1,0).
- k=1, P=(5,17,1) -> no ECPA ops; R=(5,17,1); o_done at cycle 10 after accept.
- k=5 (101b), P=(5,17,1) -> op log DBL(P,P), DBL(R,R), ADD(R,P); exactly 3 o_pa_start pulses, each followed by one low gap cycle; R equals the stub's third result.
- k=8'hFF -> 7 DBL and 7 ADD, strictly alternating DBL,ADD; total latency 1+1+14·6+1=87 cycles.
- i_start pulsed during an ADD with a different k -> ignored; result and op log identical to the undisturbed run.
- i_rst_n=0 mid-DBL -> o_pa_start, o_busy and o_done low immediately; after release a fresh k=3 run gives DBL then ADD and a correct o_done.
